// File: rtl/rhea_gate_sequencer_if.sv
// Request/result handshake bundle for rhea_gate_sequencer.
// slave: sequencer side; master: scheduler/consumer side.
interface rhea_gate_sequencer_if #(
    parameter int ROUNDS_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [1:0]          in_mode;
    logic [ROUNDS_W-1:0] in_rounds;
    logic [2:0]          in_a;
    logic [2:0]          in_b;
    logic [2:0]          in_g;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_a;
    logic [2:0]          out_b;
    logic [2:0]          out_g;
    logic [1:0]          out_mode;
    logic                out_err;
    logic                busy;
    logic [ROUNDS_W-1:0] round_cnt;

    modport slave (
        input  in_valid, in_mode, in_rounds, in_a, in_b, in_g,
        input  out_ready,
        output in_ready,
        output out_valid, out_a, out_b, out_g, out_mode, out_err,
        output busy, round_cnt
    );

    modport master (
        output in_valid, in_mode, in_rounds, in_a, in_b, in_g,
        output out_ready,
        input  in_ready,
        input  out_valid, out_a, out_b, out_g, out_mode, out_err,
        input  busy, round_cnt
    );
endinterface

// File: rtl/rhea_gate_sequencer.sv
// Multi-round controller: applies the reversible gate R times to one
// (A,B,G) triplet and returns the result over a valid/ready handshake.
// Ports: clk, rst (sync, active-high), bus (rhea_gate_sequencer_if.slave):
//   in_valid/in_ready/in_mode/in_rounds/in_a/in_b/in_g request side,
//   out_valid/out_ready/out_a/out_b/out_g/out_mode/out_err result side,
//   busy (RUN or DONE), round_cnt (rounds remaining).
// Optional macro RHEA_SEQ_RANGE_CHECK_EN: operand radix check at accept;
// without it out_err is tied 0.
module rhea_gate_sequencer #(
    parameter int ROUNDS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rhea_gate_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [1:0]          mode_q, mode_n;
    logic [2:0]          a_q, a_n;
    logic [2:0]          b_q, b_n;
    logic [2:0]          g_q, g_n;
    logic [ROUNDS_W-1:0] cnt_q, cnt_n;
    logic                err_q, err_n;

    // gate datapath, driven from the state registers
    logic [2:0] ga, gb, gg;
    logic [3:0] sum_ab, sum_gb;
    logic       range_err;

    assign sum_ab = {1'b0, a_q} + {1'b0, b_q};
    assign sum_gb = {1'b0, g_q} + {1'b0, b_q};

    always_comb begin
        ga = a_q;
        gb = b_q;
        gg = g_q;
        unique case (mode_q)
            2'b00: begin
                ga = {2'b00, ~(a_q[0] & b_q[0])};
                gb = 3'd0;
            end
            2'b01: begin
                gb = 3'(sum_ab % 4'd3);
                gg = 3'(sum_gb % 4'd5);
            end
            2'b10: begin
                gb = 3'(sum_ab % 4'd5);
                gg = 3'(sum_gb % 4'd5);
            end
            default: ;
        endcase
    end

`ifdef RHEA_SEQ_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        unique case (bus.in_mode)
            2'b01: range_err = (bus.in_a >= 3'd3) | (bus.in_b >= 3'd3)
                             | (bus.in_g >= 3'd5);
            2'b10: range_err = (bus.in_a >= 3'd5) | (bus.in_b >= 3'd5)
                             | (bus.in_g >= 3'd5);
            default: range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        a_n     = a_q;
        b_n     = b_q;
        g_n     = g_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    mode_n = bus.in_mode;
                    a_n    = bus.in_a;
                    b_n    = bus.in_b;
                    g_n    = bus.in_g;
                    err_n  = range_err;
                    if (range_err) begin
                        // rejected operands are returned untouched
                        cnt_n   = '0;
                        state_n = DONE;
                    end else begin
                        cnt_n   = bus.in_rounds;
                        state_n = (bus.in_rounds != '0) ? RUN : DONE;
                    end
                end
            end
            RUN: begin
                a_n   = ga;
                b_n   = gb;
                g_n   = gg;
                cnt_n = cnt_q - 1'b1;
                if (cnt_q == ROUNDS_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    err_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            g_q    <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            a_q    <= a_n;
            b_q    <= b_n;
            g_q    <= g_n;
            cnt_q  <= cnt_n;
            err_q  <= err_n;
        end
    end

    assign bus.in_ready  = (state == IDLE) & ~rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_g     = g_q;
    assign bus.out_mode  = mode_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.round_cnt = cnt_q;
endmodule

// File: tb/tb_rhea_gate_sequencer.sv
// Directed self-checking bench for rhea_gate_sequencer.
// Expected values are hand-computed from the gate arithmetic.
module tb_rhea_gate_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rhea_gate_sequencer_if #(.ROUNDS_W(4)) bus ();

    rhea_gate_sequencer #(.ROUNDS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive a request and return once it is accepted (edge + 1)
    task automatic send(input logic [1:0] m, input logic [3:0] r,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] g);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_rounds = r;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_g      = g;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // wait for out_valid; returns edges elapsed after the accept edge
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) check("valid_timeout", 0, 1);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, int'(bus.out_valid), 0);
        check({tag, "_rdy_back"}, int'(bus.in_ready), 1);
        check({tag, "_err_clr"}, int'(bus.out_err), 0);
    endtask

    task automatic txn(input string tag, input logic [1:0] m,
                       input logic [3:0] r, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] g,
                       input int ea, input int eb, input int eg,
                       input int eerr, input int elat);
        int lat;
        send(m, r, a, b, g);
        if (elat != 0) begin
            check({tag, "_cnt0"}, int'(bus.round_cnt), int'(r));
            check({tag, "_busy"}, int'(bus.busy), 1);
        end
        wait_valid(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_a"}, int'(bus.out_a), ea);
        check({tag, "_b"}, int'(bus.out_b), eb);
        check({tag, "_g"}, int'(bus.out_g), eg);
        check({tag, "_mode"}, int'(bus.out_mode), int'(m));
        check({tag, "_err"}, int'(bus.out_err), eerr);
        check({tag, "_inrdy"}, int'(bus.in_ready), 0);
        handshake(tag);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'd0;
        bus.in_rounds = 4'd0;
        bus.in_a      = 3'd0;
        bus.in_b      = 3'd0;
        bus.in_g      = 3'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_inrdy", int'(bus.in_ready), 0);
        check("rst_vld", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_a", int'(bus.out_a), 0);
        check("rst_cnt", int'(bus.round_cnt), 0);
        rst = 1'b0;
        #1;
        check("post_rst_inrdy", int'(bus.in_ready), 1);

        // ternary 3 rounds: (1,2,0)->(1,0,2)->(1,1,2)->(1,2,3)
        txn("tern3", 2'b01, 4'd3, 3'd1, 3'd2, 3'd0, 1, 2, 3, 0, 3);
        // pentary 1 round: B=(4+3)%5, G=(2+4)%5
        txn("pent1", 2'b10, 4'd1, 3'd3, 3'd4, 3'd2, 3, 2, 1, 0, 1);
        // binary 1 round: A=~(1&1)
        txn("bin1", 2'b00, 4'd1, 3'd1, 3'd1, 3'd3, 0, 0, 3, 0, 1);
        // binary 2 rounds: (0,0,1)->(1,0,1)->(1,0,1)
        txn("bin2", 2'b00, 4'd2, 3'd0, 3'd0, 3'd1, 1, 0, 1, 0, 2);
        // zero rounds echo inputs
        txn("r0", 2'b00, 4'd0, 3'd5, 3'd6, 3'd7, 5, 6, 7, 0, 0);
        // pass-through mode
        txn("pass", 2'b11, 4'd2, 3'd5, 3'd3, 3'd6, 5, 3, 6, 0, 2);

        // ternary A=3 out of range
`ifdef RHEA_SEQ_RANGE_CHECK_EN
        txn("range", 2'b01, 4'd1, 3'd3, 3'd1, 3'd0, 3, 1, 0, 1, 0);
`else
        txn("range", 2'b01, 4'd1, 3'd3, 3'd1, 3'd0, 3, 1, 1, 0, 1);
`endif

        // pentary 5 rounds with long backpressure:
        // (2,1,3)->(2,3,4)->(2,0,2)->(2,2,2)->(2,4,4)->(2,1,3)
        send(2'b10, 4'd5, 3'd2, 3'd1, 3'd3);
        // a competing request while busy must be ignored
        bus.in_valid  = 1'b1;
        bus.in_mode   = 2'b00;
        bus.in_rounds = 4'd1;
        bus.in_a      = 3'd7;
        bus.in_b      = 3'd7;
        bus.in_g      = 3'd7;
        wait_valid(lat);
        check("bp_lat", lat, 5);
        for (int i = 0; i < 10; i++) begin
            check("bp_vld", int'(bus.out_valid), 1);
            check("bp_inrdy", int'(bus.in_ready), 0);
            check("bp_abg", int'({bus.out_a, bus.out_b, bus.out_g}),
                  int'({3'd2, 3'd1, 3'd3}));
            check("bp_mode", int'(bus.out_mode), 2);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        handshake("bp");

        // reset in the 2nd RUN cycle of an 8-round transaction
        send(2'b01, 4'd8, 3'd1, 3'd1, 3'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_inrdy", int'(bus.in_ready), 0);
        check("abort_vld", int'(bus.out_valid), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_abg", int'({bus.out_a, bus.out_b, bus.out_g}), 0);
        check("abort_cnt", int'(bus.round_cnt), 0);
        check("abort_mode", int'(bus.out_mode), 0);
        rst = 1'b0;
        #1;
        check("abort_rdy_back", int'(bus.in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_vld", int'(bus.out_valid), 0);
        end

        // normal operation after the abort: (1,2,0)->(1,0,2)
        txn("after", 2'b01, 4'd1, 3'd1, 3'd2, 3'd0, 1, 0, 2, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
